// File: rtl/commit_store_arbiter.sv
// commit_store_arbiter: shares one data-memory port between LSU loads and committed store drains.
// Optional COMMIT_STORE_STARVE_GUARD_EN forces a store after STARVE_LIMIT consecutive load grants.
module commit_store_arbiter #(
  parameter int DEPTH        = 8,
  parameter int HIGH_WATER   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fire_store0,
  input  logic                       fire_store1,
  input  logic                       flush,
  input  logic                       ld_req_valid,
  output logic                       ld_req_ready,
  output logic                       ld_resp_valid,
  output logic                       mem_req_valid,
  output logic                       mem_req_is_store,
  input  logic                       mem_req_ready,
  input  logic                       mem_resp_valid,
  output logic                       sq_pop,
  output logic                       commit_stall,
  output logic [$clog2(DEPTH+1)-1:0] committed_cnt,
  output logic                       err_overflow
);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [1:0] IDLE = 2'd0, WAIT_ST = 2'd1, WAIT_LD = 2'd2;
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0] sum;
  logic err_q, err_d, killed_q, killed_d, held_q, held_d, held_st_q, held_st_d;
  logic force_store, store_pick, pick_st, go;
  assign committed_cnt = cnt_q;
  assign err_overflow = err_q;
  assign commit_stall = cnt_q >= CW'(DEPTH-1);
  // an unaccepted request keeps its type; only a held load may be dropped by flush
  always_comb begin
    store_pick = cnt_q != '0 && (cnt_q >= CW'(HIGH_WATER) || !ld_req_valid || force_store);
    pick_st = held_q ? held_st_q : store_pick;
    go = rst_n && state_q == IDLE && (held_q || store_pick || ld_req_valid) && (pick_st || !flush);
    mem_req_valid = go;
    mem_req_is_store = go && pick_st;
    ld_req_ready = go && !pick_st && mem_req_ready;
    sq_pop = go && pick_st && mem_req_ready;
    ld_resp_valid = state_q == WAIT_LD && mem_resp_valid && !killed_q && !flush;
    held_d = go && !mem_req_ready;
    held_st_d = pick_st;
    state_d = sq_pop ? WAIT_ST : ld_req_ready ? WAIT_LD :
              (state_q != IDLE && mem_resp_valid) ? IDLE : state_q;
    killed_d = state_q == WAIT_LD && !mem_resp_valid && (killed_q || flush);
    sum = {1'b0, cnt_q} + (CW+1)'(fire_store0) + (CW+1)'(fire_store1) - (CW+1)'(sq_pop);
    cnt_d = sum > (CW+1)'(DEPTH) ? CW'(DEPTH) : sum[CW-1:0];
    err_d = err_q || sum > (CW+1)'(DEPTH);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      killed_q  <= 1'b0;
      held_q    <= 1'b0;
      held_st_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      killed_q  <= killed_d;
      held_q    <= held_d;
      held_st_q <= held_st_d;
    end
  end
`ifdef COMMIT_STORE_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT+1);
  logic [SW-1:0] starve_q, starve_d;
  assign force_store = starve_q == SW'(STARVE_LIMIT);
  always_comb begin
    starve_d = (cnt_q == '0 || sq_pop) ? '0 : (ld_req_ready && !force_store) ? starve_q + 1'b1 : starve_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else starve_q <= starve_d;
  end
`else
  assign force_store = 1'b0;
`endif
endmodule

// File: tb/tb_commit_store_arbiter.sv
// tb_commit_store_arbiter: scoreboard bench; expected grant kinds (1 = store, 0 = load) are queued
// as stimulus is driven and popped as the DUT's memory requests are accepted.
module tb_commit_store_arbiter;
  logic clk = 1'b0;
  logic rst_n, fire_store0, fire_store1, flush, ld_req_valid, mem_req_ready, mem_resp_valid;
  logic ld_req_ready, ld_resp_valid, mem_req_valid, mem_req_is_store, sq_pop, commit_stall, err_overflow;
  logic [3:0] committed_cnt;
  int n_chk = 0, n_err = 0, n_grant = 0, n_ld_resp = 0, exp_ld = 0, cyc = 0, last_grant = 0;
  int resp_delay = 1;
  bit exp_q[$];
  bit e;

  commit_store_arbiter dut (
    .clk(clk), .rst_n(rst_n), .fire_store0(fire_store0), .fire_store1(fire_store1), .flush(flush),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_resp_valid(ld_resp_valid),
    .mem_req_valid(mem_req_valid), .mem_req_is_store(mem_req_is_store), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .sq_pop(sq_pop), .commit_stall(commit_stall),
    .committed_cnt(committed_cnt), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fire(input logic a, input logic b);
    fire_store0 = a;
    fire_store1 = b;
    tick();
    fire_store0 = 1'b0;
    fire_store1 = 1'b0;
  endtask

  task automatic wait_empty;
    int k;
    for (k = 0; k < 300 && exp_q.size() != 0; k++) tick();
    if (exp_q.size() != 0) begin
      chk("grant_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic drain(input int n);
    repeat (n) exp_q.push_back(1'b1);
    wait_empty();
    repeat (4) tick();
    chk("drained_cnt", committed_cnt, 0);
  endtask

  // memory model: acks each accepted request resp_delay cycles later
  initial begin
    mem_resp_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req_valid && mem_req_ready) begin
        @(posedge clk);
        repeat (resp_delay - 1) @(posedge clk);
        #3 mem_resp_valid = 1'b1;
        @(posedge clk);
        #3 mem_resp_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && mem_req_valid && mem_req_ready) begin
      if (exp_q.size() == 0) chk("unexpected_grant", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("grant_kind", mem_req_is_store, e);
        chk("sq_pop", sq_pop, e);
        chk("ld_req_ready", ld_req_ready, !e);
      end
      if (n_grant > 0) chk("spacing_ok", (cyc - last_grant) >= 2, 1);
      last_grant = cyc;
      n_grant++;
    end
    if (ld_resp_valid) n_ld_resp++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; fire_store0 = 1'b0; fire_store1 = 1'b0; flush = 1'b0;
    ld_req_valid = 1'b0; mem_req_ready = 1'b0;
    #2;
    chk("rst_cnt", committed_cnt, 0);
    chk("rst_err", err_overflow, 0);
    chk("rst_req", mem_req_valid, 0);
    chk("rst_stall", commit_stall, 0);
    chk("rst_pop", sq_pop, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    // dual commit, both stores drain back to back
    mem_req_ready = 1'b1;
    fire(1'b1, 1'b1);
    #1 chk("dual_cnt", committed_cnt, 2);
    drain(2);
    // loads win below the high-water mark
    ld_req_valid = 1'b1; mem_req_ready = 1'b0;
    tick();
    fire(1'b1, 1'b1);
    #1 chk("lw_cnt", committed_cnt, 2);
    chk("lw_held_load", mem_req_is_store, 0);
    exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_ld += 2;
    mem_req_ready = 1'b1;
    wait_empty();
    fire(1'b1, 1'b1);
    exp_q.push_back(1'b1);
    wait_empty();
    ld_req_valid = 1'b0;
    drain(3);
    chk("lw_ld_resp", n_ld_resp, exp_ld);
    // overflow
    mem_req_ready = 1'b0;
    fire(1'b1, 1'b1); fire(1'b1, 1'b1); fire(1'b1, 1'b1);
    #1 chk("stall_at6", commit_stall, 0);
    fire(1'b1, 1'b0);
    #1 chk("stall_at7", commit_stall, 1);
    chk("no_err_at7", err_overflow, 0);
    fire(1'b1, 1'b1);
    #1 chk("sat_cnt", committed_cnt, 8);
    chk("ovf_err", err_overflow, 1);
    mem_req_ready = 1'b1;
    drain(8);
    chk("err_sticky", err_overflow, 1);
    chk("stall_clear", commit_stall, 0);
    // flush drops a held load but never a held store
    ld_req_valid = 1'b1; mem_req_ready = 1'b0;
    tick();
    #1 chk("ld_held", mem_req_valid, 1);
    flush = 1'b1;
    #1 chk("flush_drop", mem_req_valid, 0);
    tick();
    flush = 1'b0; ld_req_valid = 1'b0;
    #1 chk("drop_kept", mem_req_valid, 0);
    fire(1'b1, 1'b0);
    tick();
    flush = 1'b1;
    #1 chk("flush_keeps_st", mem_req_is_store, 1);
    tick();
    flush = 1'b0;
    chk("flush_cnt", committed_cnt, 1);
    mem_req_ready = 1'b1;
    drain(1);
    // flush while a load is in flight kills its response
    resp_delay = 4;
    ld_req_valid = 1'b1;
    exp_q.push_back(1'b0);
    wait_empty();
    ld_req_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (6) tick();
    chk("killed_resp", n_ld_resp, exp_ld);
    chk("killed_cnt", committed_cnt, 0);
    resp_delay = 1;
    // starvation with a single pending store
    ld_req_valid = 1'b1; mem_req_ready = 1'b0;
    tick();
    fire(1'b1, 1'b0);
    mem_req_ready = 1'b1;
`ifdef COMMIT_STORE_STARVE_GUARD_EN
    exp_q = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_ld += 4;
    wait_empty();
    ld_req_valid = 1'b0;
    drain(0);
`else
    exp_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_ld += 6;
    wait_empty();
    chk("starve_cnt", committed_cnt, 1);
    ld_req_valid = 1'b0;
    drain(1);
`endif
    chk("starve_ld_resp", n_ld_resp, exp_ld);
    // async reset in the middle of a store drain
    resp_delay = 10; mem_req_ready = 1'b0;
    fire(1'b1, 1'b1); fire(1'b1, 1'b0);
    exp_q.push_back(1'b1);
    mem_req_ready = 1'b1;
    wait_empty();
    fire(1'b1, 1'b0);
    #1 chk("pre_rst_cnt", committed_cnt, 3);
    rst_n = 1'b0;
    #1 chk("arst_cnt", committed_cnt, 0);
    chk("arst_req", mem_req_valid, 0);
    chk("arst_pop", sq_pop, 0);
    chk("arst_err", err_overflow, 0);
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("post_rst_req", mem_req_valid, 0);
    chk("post_rst_cnt", committed_cnt, 0);
    chk("post_rst_queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/commit_store_arbiter.md
Name: commit_store_arbiter

Overview:
- Sequences the single data-memory request port between speculative loads from the LSU and committed stores released by Commit (`fireStore`/`fireStore1`).
- Counts committed-but-undrained stores and pops the store-queue head once memory accepts each store.
- Back-pressures Commit before the count can overflow.
- Keeps load responses from being delivered across a pipeline flush.

Parameters:
- DEPTH, 8, committed-store capacity; equals store-queue entries.
- HIGH_WATER, 4, count at or above which stores take priority over loads.
- STARVE_LIMIT, 3, consecutive load grants with stores pending before a store is forced (used only with the optional feature).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- fire_store0  input  1  slot-0 store committed this cycle
- fire_store1  input  1  slot-1 store committed this cycle; may assert without fire_store0
- flush  input  1  pipeline flush (Ctrl flushReq)
- ld_req_valid  input  1  LSU load request pending
- ld_req_ready  output  1  load accepted by memory this cycle
- ld_resp_valid  output  1  load data valid to LSU
- mem_req_valid  output  1  request to data memory
- mem_req_is_store  output  1  1 = store drain, 0 = load
- mem_req_ready  input  1  memory accepts request
- mem_resp_valid  input  1  memory completion (load data or store ack)
- sq_pop  output  1  pop store-queue head (pulse)
- commit_stall  output  1  Commit must not fire stores this cycle
- committed_cnt  output  $clog2(DEPTH+1)  undrained committed stores
- err_overflow  output  1  sticky protocol-violation flag

Behaviour:
- Reset (rst_n low, async): state IDLE, committed_cnt 0, starve 0, killed 0, err_overflow 0. All pulse outputs are 0.
- Count update per cycle: cnt_next = cnt + fire_store0 + fire_store1 - sq_pop. All three terms may occur in the same cycle.
- If cnt_next would exceed DEPTH: saturate at DEPTH and set err_overflow; it clears only on reset.
- commit_stall = (cnt >= DEPTH-1), combinational. This guarantees room for a dual-store commit.
- FSM states: IDLE, WAIT_ST, WAIT_LD. Only one memory request is outstanding at a time.
- IDLE, store_pick = (cnt != 0) && (cnt >= HIGH_WATER || !ld_req_valid || force_store):
  - Store pick: mem_req_valid = 1, mem_req_is_store = 1. When mem_req_ready is high: sq_pop = 1 in the same cycle, then go to WAIT_ST.
  - Otherwise, if ld_req_valid: mem_req_valid = 1, mem_req_is_store = 0, ld_req_ready = mem_req_ready. When accepted, go to WAIT_LD.
  - Once mem_req_valid is raised, the request is held (with the same is_store) until mem_req_ready is seen. No re-arbitration while it is unaccepted.
- WAIT_ST: on mem_resp_valid, go to IDLE.
- WAIT_LD: on mem_resp_valid, go to IDLE. ld_resp_valid = mem_resp_valid && !killed && !flush.
- Flush handling:
  - flush in WAIT_LD sets killed; the response is still consumed but never delivered. killed clears on leaving WAIT_LD.
  - flush in IDLE with a load request held unaccepted drops that request: mem_req_valid goes to 0 that cycle.
  - flush never changes committed_cnt, and never cancels a store, pending or in flight. Committed stores must drain.
- Minimum spacing: a new request may issue no earlier than the cycle after mem_resp_valid.
- mem_resp_valid in IDLE is ignored.
- Reset mid-transaction returns to IDLE with count 0; the memory side is reset by the same rst_n.

Optional Feature:
- Macro: COMMIT_STORE_STARVE_GUARD_EN.
- Defined:
  - starve counter increments on each load grant while cnt != 0, saturating at STARVE_LIMIT.
  - It resets to 0 on each store grant, or when cnt == 0.
  - force_store = (starve == STARVE_LIMIT).
- Undefined: force_store = 0; no starve register exists. Loads can hold off stores until HIGH_WATER is reached.

Test Plan:
- Reset, then fire_store0 and fire_store1 together with no loads and mem_req_ready = 1:
  - committed_cnt reaches 2.
  - Two store requests issue, each followed by sq_pop and the ack.
  - committed_cnt returns to 0.
  - Stores are spaced at least 2 cycles apart.
- cnt = 2 with ld_req_valid held high: loads win every IDLE arbitration. Then fire two more stores (cnt = 4 = HIGH_WATER) → the next grant is a store, with ld_req_ready = 0 that cycle.
- Fire stores until cnt = 7 → commit_stall = 1.
  - A further dual fire at cnt = 7 saturates the count at 8 and sets err_overflow.
  - err_overflow stays 1 until rst_n is asserted.
- Load accepted, flush asserted the next cycle, mem_resp_valid 3 cycles later → ld_resp_valid stays 0, FSM returns to IDLE, committed_cnt unchanged.
- With COMMIT_STORE_STARVE_GUARD_EN defined: cnt = 1, continuous loads → 3 load grants, then 1 store grant, then loads resume. Undefined: the store never issues while loads persist.
- rst_n pulsed low during WAIT_ST with cnt = 3 → committed_cnt = 0, no sq_pop, mem_req_valid = 0 immediately (asynchronously).
